// File: rtl/reg_file_pkg.sv
// Shared constants, index type and bus-slicing helper for the parametrised register file.
// Optional write-to-read bypass is selected by defining REG_FILE_BYPASS_EN.
package reg_file_pkg;

  localparam int ZERO_REG   = 0;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 32;

  typedef logic [$clog2(DEF_DEPTH)-1:0] reg_idx_t;

  // Low bit of lane 'port' in a flattened bus of 'width'-bit lanes.
  function automatic int bus_lsb(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending scoreboard: issue sets, writeback clears, set wins on a collision.
// With REG_FILE_BYPASS_EN an in-flight writeback also masks the pending flag on matching read ports.
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int NUM_RD = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          we,
  input  logic [$clog2(DEPTH)-1:0]      wa,
  input  logic [NUM_RD*$clog2(DEPTH)-1:0] ra,
  input  logic                          iss_valid,
  input  logic [$clog2(DEPTH)-1:0]      iss_rd,
  output logic [NUM_RD-1:0]             rd_pend,
  output logic                          any_pend
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] R0 = ADDR_W'(ZERO_REG);

  logic [DEPTH-1:0] pending;

  // The set is written last so a new producer overrides the retiring one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else begin
      if (we && wa != R0)
        pending[wa] <= 1'b0;
      if (iss_valid && iss_rd != R0)
        pending[iss_rd] <= 1'b1;
    end
  end

  assign any_pend = |pending;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_pend
    logic [ADDR_W-1:0] a;
    assign a = ra[bus_lsb(i, ADDR_W) +: ADDR_W];
`ifdef REG_FILE_BYPASS_EN
    assign rd_pend[i] = (a != R0) && pending[a] && !(we && wa == a);
`else
    assign rd_pend[i] = (a != R0) && pending[a];
`endif
  end

endmodule

// File: rtl/reg_file_sb.sv
// Decode-stage register file: zero register, N combinational read ports, hazard scoreboard.
// Define REG_FILE_BYPASS_EN for write-first forwarding of the writeback data to the read ports.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int NUM_RD = 2,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  logic [ADDR_W-1:0]          wa,
  input  logic [DATA_W-1:0]          wd,
  input  logic [NUM_RD*ADDR_W-1:0]   ra,
  output logic [NUM_RD*DATA_W-1:0]   rd,
  output logic [NUM_RD-1:0]          rd_pend,
  input  logic                       iss_valid,
  input  logic [ADDR_W-1:0]          iss_rd,
  output logic                       any_pend
);

  localparam logic [ADDR_W-1:0] R0 = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < DEPTH; j++)
        mem[j] <= '0;
    end else if (we && wa != R0) begin
      mem[wa] <= wd;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] rdv;
    assign a = ra[bus_lsb(i, ADDR_W) +: ADDR_W];

    // Register 0 reads zero regardless of array contents.
    always_comb begin
      rdv = mem[a];
`ifdef REG_FILE_BYPASS_EN
      if (we && wa != R0 && wa == a)
        rdv = wd;
`endif
      if (a == R0)
        rdv = '0;
    end

    assign rd[bus_lsb(i, DATA_W) +: DATA_W] = rdv;
  end

  reg_scoreboard #(
    .DEPTH  (DEPTH),
    .NUM_RD (NUM_RD)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .we        (we),
    .wa        (wa),
    .ra        (ra),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .rd_pend   (rd_pend),
    .any_pend  (any_pend)
  );

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb (4 ports, 64 x 64-bit), valid with or without REG_FILE_BYPASS_EN.
module tb_reg_file_sb;

  localparam int DW = 64;
  localparam int DP = 64;
  localparam int NR = 4;
  localparam int AW = 6;
`ifdef REG_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             we;
  logic [AW-1:0]    wa;
  logic [DW-1:0]    wd;
  logic [NR*AW-1:0] ra;
  logic [NR*DW-1:0] rd;
  logic [NR-1:0]    rd_pend;
  logic             iss_valid;
  logic [AW-1:0]    iss_rd;
  logic             any_pend;

  int total = 0;
  int bad   = 0;

  // Reference state: register contents and outstanding-producer flags.
  logic [DW-1:0] m_reg  [DP];
  bit            m_pend [DP];

  reg_file_sb #(.DATA_W(DW), .DEPTH(DP), .NUM_RD(NR)) dut (
    .clk       (clk),
    .rst       (rst),
    .we        (we),
    .wa        (wa),
    .wd        (wd),
    .ra        (ra),
    .rd        (rd),
    .rd_pend   (rd_pend),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .any_pend  (any_pend)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [AW-1:0] ra0, ra1;
    logic          iv;
    logic [AW-1:0] ird;
    logic [DW-1:0] e_rd0, e_rd1;
    logic          e_p0, e_p1, e_any;
  } vec_t;

  vec_t tbl [13];

  function automatic vec_t mk(input logic w, input int a, input logic [DW-1:0] d,
                              input int r0, input int r1, input logic iv, input int ir,
                              input logic [DW-1:0] x0, input logic [DW-1:0] x1,
                              input logic p0, input logic p1, input logic an);
    vec_t v;
    v.we = w; v.wa = AW'(a); v.wd = d; v.ra0 = AW'(r0); v.ra1 = AW'(r1);
    v.iv = iv; v.ird = AW'(ir); v.e_rd0 = x0; v.e_rd1 = x1;
    v.e_p0 = p0; v.e_p1 = p1; v.e_any = an;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                               input logic [NR*AW-1:0] r, input logic iv, input logic [AW-1:0] ir);
    we = w; wa = a; wd = d; ra = r; iss_valid = iv; iss_rd = ir;
  endtask

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (BYP && we && wa == a) return wd;
    return m_reg[a];
  endfunction

  function automatic logic exp_pend(input logic [AW-1:0] a);
    if (a == 0) return 1'b0;
    if (BYP && we && wa == a) return 1'b0;
    return m_pend[a];
  endfunction

  function automatic logic exp_any();
    for (int k = 0; k < DP; k++)
      if (m_pend[k]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic checkOutput(input string name);
    for (int p = 0; p < NR; p++) begin
      cmp($sformatf("%s rd%0d", name, p), rd[p*DW +: DW], exp_rd(ra[p*AW +: AW]));
      cmp($sformatf("%s rd_pend%0d", name, p), DW'(rd_pend[p]), DW'(exp_pend(ra[p*AW +: AW])));
    end
    cmp($sformatf("%s any_pend", name), DW'(any_pend), DW'(exp_any()));
  endtask

  task automatic model_reset();
    for (int k = 0; k < DP; k++) begin
      m_reg[k] = '0;
      m_pend[k] = 1'b0;
    end
  endtask

  // Advance one clock: commit the architectural effect of the inputs seen at the edge.
  task automatic tick();
    @(posedge clk);
    if (we && wa != 0) begin
      m_reg[wa] = wd;
      m_pend[wa] = 1'b0;
    end
    if (iss_valid && iss_rd != 0)
      m_pend[iss_rd] = 1'b1;
    @(negedge clk);
  endtask

  function automatic logic [NR*AW-1:0] pack_ra(input int a0, input int a1, input int a2, input int a3);
    return {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
  endfunction

  function automatic logic [AW-1:0] rnd_addr();
    if ($urandom_range(0, 9) == 0) return AW'($urandom_range(0, DP - 1));
    return AW'($urandom_range(0, 7));
  endfunction

  initial begin
    logic [DW-1:0] bdata;
    logic [DW-1:0] ones;
    ones = '1;

    tbl[0]  = mk(0, 0, 0,      5, 4, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 5, 39,     5, 0, 0, 0, BYP ? 64'd39 : 64'd0, 0, 0, 0, 0);
    tbl[2]  = mk(1, 4, 32,     5, 4, 0, 0, 39, BYP ? 64'd32 : 64'd0, 0, 0, 0);
    tbl[3]  = mk(0, 0, 0,      5, 4, 0, 0, 39, 32, 0, 0, 0);
    tbl[4]  = mk(1, 0, 77,     0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[5]  = mk(0, 0, 0,      0, 9, 1, 9, 0, 0, 0, 0, 0);
    tbl[6]  = mk(0, 0, 0,      9, 0, 0, 0, 0, 0, 1, 0, 1);
    tbl[7]  = mk(1, 9, 'h1234, 9, 0, 0, 0, BYP ? 64'h1234 : 64'd0, 0, !BYP, 0, 1);
    tbl[8]  = mk(0, 0, 0,      9, 0, 0, 0, 'h1234, 0, 0, 0, 0);
    tbl[9]  = mk(1, 3, 'hAB,   3, 0, 1, 3, BYP ? 64'hAB : 64'd0, 0, 0, 0, 0);
    tbl[10] = mk(0, 0, 0,      3, 0, 0, 0, 'hAB, 0, 1, 0, 1);
    tbl[11] = mk(1, 3, 'hCD,   3, 0, 1, 0, BYP ? 64'hCD : 64'hAB, 0, !BYP, 0, 1);
    tbl[12] = mk(0, 0, 0,      3, 0, 0, 0, 'hCD, 0, 0, 0, 0);

    rst = 1'b1;
    applyStimulus(0, 0, 0, '0, 0, 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #2;
    cmp("reset any_pend", DW'(any_pend), 0);
    cmp("reset rd0", rd[0 +: DW], 0);
    @(negedge clk);

    // Directed table: write/read, r0 immunity, scoreboard set/clear and collisions.
    for (int i = 0; i < 13; i++) begin
      applyStimulus(tbl[i].we, tbl[i].wa, tbl[i].wd, pack_ra(tbl[i].ra0, tbl[i].ra1, 0, 0),
                    tbl[i].iv, tbl[i].ird);
      #2;
      cmp($sformatf("tbl%0d rd0", i), rd[0 +: DW], tbl[i].e_rd0);
      cmp($sformatf("tbl%0d rd1", i), rd[DW +: DW], tbl[i].e_rd1);
      cmp($sformatf("tbl%0d rd_pend0", i), DW'(rd_pend[0]), DW'(tbl[i].e_p0));
      cmp($sformatf("tbl%0d rd_pend1", i), DW'(rd_pend[1]), DW'(tbl[i].e_p1));
      cmp($sformatf("tbl%0d any_pend", i), DW'(any_pend), DW'(tbl[i].e_any));
      tick();
    end

    // Same-cycle write and read of r7.
    bdata = 64'hDEAD_BEEF;
    applyStimulus(1, 7, bdata, pack_ra(7, 0, 0, 0), 0, 0);
    #2;
    cmp("bypass same-cycle rd0", rd[0 +: DW], BYP ? bdata : 64'd0);
    tick();
    applyStimulus(0, 0, 0, pack_ra(7, 0, 0, 0), 0, 0);
    #2;
    cmp("bypass next-cycle rd0", rd[0 +: DW], bdata);
    tick();

    // All four ports on the top register.
    applyStimulus(1, 63, ones, pack_ra(0, 0, 0, 0), 0, 0);
    tick();
    applyStimulus(0, 0, 0, pack_ra(63, 63, 63, 63), 0, 0);
    #2;
    for (int p = 0; p < NR; p++)
      cmp($sformatf("multiport rd%0d", p), rd[p*DW +: DW], ones);
    tick();

    // Asynchronous reset mid-cycle while a write to r5 is pending and r10 is outstanding.
    applyStimulus(0, 0, 0, pack_ra(5, 0, 0, 0), 1, 10);
    tick();
    applyStimulus(1, 5, 64'd99, pack_ra(5, 10, 0, 0), 0, 0);
    #2;
    cmp("pre-reset any_pend", DW'(any_pend), 1);
    cmp("pre-reset rd0", rd[0 +: DW], BYP ? 64'd99 : 64'd39);
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    cmp("async reset rd0", rd[0 +: DW] & {DW{!BYP}}, 0);
    cmp("async reset rd1", rd[DW +: DW], 0);
    cmp("async reset rd_pend1", DW'(rd_pend[1]), 0);
    cmp("async reset any_pend", DW'(any_pend), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    applyStimulus(0, 0, 0, pack_ra(5, 4, 9, 63), 0, 0);
    #2;
    checkOutput("post-reset");
    tick();

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      applyStimulus($urandom_range(0, 1), rnd_addr(), {$urandom(), $urandom()},
                    pack_ra(rnd_addr(), rnd_addr(), rnd_addr(), rnd_addr()),
                    $urandom_range(0, 2) == 0, rnd_addr());
      #2;
      checkOutput($sformatf("rand%0d", n));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised successor to the 2-read/1-write CPU register file.
- Adds the following over that file:
  - configurable data width, depth and read-port count;
  - register 0 hardwired to zero;
  - optional write-to-read bypass;
  - a per-register pending scoreboard for pipeline hazard detection.
- Sits in the decode stage of the pipelined RISC-V core.
  - Decode reads operands, marks the destination busy on issue, and stalls on pending sources.
  - Writeback clears the busy mark.

Parameters:
- DATA_W, 32, register width in bits.
- DEPTH, 32, number of registers; must be a power of 2 and at least 2.
- NUM_RD, 2, number of read ports, 1..4.
- ADDR_W, $clog2(DEPTH), register index width (derived; do not override).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-high.
- we  in  1  writeback enable.
- wa  in  ADDR_W  writeback address.
- wd  in  DATA_W  writeback data.
- ra  in  NUM_RD*ADDR_W  read addresses, port i at [i*ADDR_W +: ADDR_W].
- rd  out  NUM_RD*DATA_W  read data, port i at [i*DATA_W +: DATA_W].
- rd_pend  out  NUM_RD  port i source register is still pending.
- iss_valid  in  1  an instruction is issuing that has a destination.
- iss_rd  in  ADDR_W  issuing destination register.
- any_pend  out  1  OR of all pending bits.

Behaviour:
- Reset (async assert, any time): all registers = 0 and all pending bits = 0.
  - rd outputs follow the zeroed array combinationally; rd_pend = 0; any_pend = 0.
  - Reset mid-write discards the write.
- Write: on posedge clk with we=1 and wa!=0, reg[wa] <= wd. Writes to 0 are ignored.
- Read: combinational, zero cycles.
  - rd[i] = 0 if ra[i]==0, otherwise reg[ra[i]] (see bypass).
  - All ports are independent; any number of ports may read the same address.
- Scoreboard (pending[DEPTH] flops):
  - Set: posedge with iss_valid=1 and iss_rd!=0 sets pending[iss_rd].
  - Clear: posedge with we=1 and wa!=0 clears pending[wa].
  - Same register set and cleared in one cycle: set wins (the new producer overrides the retiring one). Result pending=1.
  - Different registers in one cycle: both actions apply.
  - pending[0] is constant 0.
  - Setting an already-pending register: it stays 1 (no counting; one outstanding producer per register is guaranteed by the issue logic).
  - Clearing a non-pending register: it stays 0, no error.
- rd_pend[i] = pending[ra[i]] AND NOT(we AND wa==ra[i] AND ra[i]!=0).
  - An in-flight writeback resolves the hazard in the same cycle.
  - ra[i]==0 gives 0.
- any_pend = OR of pending[]; it is a registered view (reflects flop state, not this cycle's iss/we).
- No X propagation: out-of-range addresses are impossible by the ADDR_W construction.

Optional Feature:
- Macro REG_FILE_BYPASS_EN.
  - Defined: when we=1, wa!=0 and wa==ra[i], rd[i]=wd in the same cycle (write-first).
  - Undefined: rd[i] returns the old reg[ra[i]]. The new value is visible from the cycle after the write edge.
- The rd_pend masking by an in-flight writeback applies only when REG_FILE_BYPASS_EN is defined.
  - Undefined: rd_pend[i] = pending[ra[i]] (the stall lasts one extra cycle until the array holds the data).

Decomposition:
- Package reg_file_pkg:
  - constant ZERO_REG = 0;
  - default DATA_W/DEPTH constants;
  - typedef reg_idx_t for the index;
  - a function that slices a flattened port bus.
- Sub-module reg_scoreboard:
  - parameters DEPTH, NUM_RD;
  - holds the pending flops, the set/clear priority logic, rd_pend and any_pend.
  - The top level holds the data array, read muxes and bypass.

Test Plan:
- Reset then read: assert rst mid-run with reg5=39 -> rd for ra=5 reads 0 immediately (asynchronously); rd_pend=0; any_pend=0.
- Write/read: write 39 to r5, then 32 to r4; next cycle ra0=5, ra1=4 -> rd0=39, rd1=32. Write 77 to r0 -> reading r0 returns 0.
- Bypass, REG_FILE_BYPASS_EN defined: same cycle we=1, wa=7, wd=0xDEAD_BEEF, ra0=7 -> rd0=0xDEADBEEF combinationally.
  - Undefined: rd0 = old value (0); 0xDEADBEEF appears after the edge.
- Scoreboard: issue r9 -> next cycle ra0=9 gives rd_pend0=1 and any_pend=1; writeback r9 -> rd_pend0 drops.
  - Drops in the writeback cycle if the macro is defined, otherwise the cycle after.
  - any_pend=0 after the edge.
- Simultaneous: iss_rd=3 and wa=3 (we=1) in one cycle -> pending[3]=1 after the edge and r3 holds new wd.
  - iss_rd=0 -> no pending bit is set.
- Multi-port: NUM_RD=4, DEPTH=64, DATA_W=64; all four ports read r63 after writing 0xFFFF_FFFF_FFFF_FFFF -> all rd equal that value.
